sdc_rd_blk_packer: RTL
======================

# sdc_rd_blk_packer

Upstream write stage for the SD-card read path's 1024x36 dual-port block RAM. Accepts the byte stream of 512-byte SD data blocks and packs 4 bytes per 36-bit word. Writes each block into one of 8 fixed 128-word RAM slots through RAM port A. Commits a slot only on good CRC, and tracks slot occupancy against a downstream consumer that drains via port B.

## Interface
- `SLOT_BITS`, 3: log2 of the slot count; address = {slot, word_idx[6:0]}, total 10 bits.
- `WORDS_PER_BLK`, 128: words per block; fixed at 512 bytes / 4.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  reset, asynchronous assert, active-low.
- `blk_start`  in  1  one-cycle pulse; a new block's bytes follow.
- `byte_in`  in  8  data byte.
- `byte_vld`  in  1  `byte_in` valid this cycle.
- `crc_ok`  in  1  one-cycle pulse after the last byte; block CRC good.
- `crc_err`  in  1  one-cycle pulse after the last byte; block CRC bad.
- `blk_rd_done`  in  1  one-cycle pulse; consumer has finished the oldest slot.
- `clr_flags`  in  1  clears the sticky flags and `err_cnt`.
- `rdy`  out  1  high in IDLE when not full; `blk_start` is accepted only while `rdy` is high.
- `bram_addr`  out  10  port A address.
- `bram_din`  out  36  port A write data.
- `bram_wr`  out  1  port A write strobe.
- `blk_done`  out  1  one-cycle pulse; a block was committed.
- `blk_slot`  out  3  slot index committed; valid with `blk_done`.
- `blk_cnt`  out  4  occupied slots, range 0..8.
- `err_cnt`  out  8  CRC-failed blocks; saturates at 255.
- `byte_drop`  out  1  sticky; a byte arrived outside FILL.

## Operation
- **Reset values.** All outputs 0 except `rdy` = 1. State IDLE, `wr_slot` = 0, `rd_slot` = 0.
- **IDLE.** `blk_start` with `rdy` high moves to FILL and clears byte_idx (2 bits) and word_idx (7 bits). A `blk_start` while not ready is ignored.
- **FILL, byte packing.** Each `byte_vld` places the byte into lane byte_idx, little-endian: byte 0 goes to [7:0].
- **FILL, word write.** On the 4th byte, issue a word write of {SOB, EOB, 2'b00, data[31:0]}.
  - SOB (bit 35) is set when word_idx = 0.
  - EOB (bit 34) is set when word_idx = 127.
  - The write address is {wr_slot, word_idx}; word_idx then increments.
- **FILL exit.** After word 127 is written, move to WAIT_CRC.
- **WAIT_CRC, good CRC.** `crc_ok`: `blk_done` = 1, `blk_slot` = `wr_slot`, `wr_slot` += 1 (wraps 7 to 0), `blk_cnt` += 1, then IDLE.
- **WAIT_CRC, bad CRC.** `crc_err`: the slot is not committed, `wr_slot` is unchanged (the next block overwrites it), `err_cnt` += 1 saturating, then IDLE.
- **Both CRC pulses together.** Treated as `crc_err`.
- **Consumer drain.** `blk_rd_done` with `blk_cnt` > 0: `blk_cnt` -= 1, `rd_slot` += 1. With `blk_cnt` = 0 it is ignored.
- **Simultaneous commit and drain.** `blk_cnt` is unchanged; both slot pointers advance.
- **Full.** When `blk_cnt` = 8, `rdy` = 0.
- **Stray bytes.** A `byte_vld` in IDLE or WAIT_CRC is discarded and sets `byte_drop`.
- **Stray CRC pulses.** `crc_ok`/`crc_err` outside WAIT_CRC are ignored.
- **Flag clear.** `clr_flags` clears `byte_drop` and `err_cnt`; a new event in the same cycle wins.
- **Reset mid-block.** Everything returns to reset values; a partial block is abandoned and RAM contents are left as-is.

## Timing
- `bram_wr`, `bram_addr`, `bram_din` are registered. `bram_wr` is high for exactly the one cycle after the 4th byte's `byte_vld` cycle.
- Back-to-back `byte_vld` is supported at 1 byte/clk, giving at most 1 word write per 4 clk.
- `blk_done`, `blk_cnt`, `rdy` update in the cycle after `crc_ok`. `rdy` goes high the cycle after the IDLE entry.
- `blk_cnt` reflects `blk_rd_done` one cycle after the pulse.
- Minimum block period is 512 byte cycles + 1 FILL entry + 1 CRC cycle + 1 IDLE cycle.

## Structure
- A shared package `sdc_rd_pkg` holds:
  - the state enum (IDLE, FILL, WAIT_CRC);
  - SOB_BIT = 35 and EOB_BIT = 34;
  - BRAM_AW = 10, BRAM_DW = 36.
- One natural sub-module, `sdc_byte_to_word`: the byte-lane shift register, byte_idx counter and word-ready strobe.
- The FSM, slot pointers and counters stay in the top module.

## Test plan
- **Good block.** Reset, `blk_start`, bytes 0x00..0xFF repeated, then `crc_ok` → 128 writes to 0x000..0x07F.
  - First word 0x8_03020100 (SOB).
  - Last word 0x4_FFFEFDFC (EOB).
  - `blk_done` with `blk_slot` = 0; `blk_cnt` = 1.
- **CRC error.** A block followed by `crc_err`, then a good block → `err_cnt` = 1; the second block is also written at 0x000..0x07F and commits as slot 0.
- **Fill to full.** 8 good blocks with no drain → `blk_cnt` = 8, `rdy` = 0, a 9th `blk_start` is ignored. One `blk_rd_done` → `blk_cnt` = 7, `rdy` = 1; the next block goes to 0x000.
- **Simultaneous commit and drain.** `blk_rd_done` in the same cycle as `crc_ok` with `blk_cnt` = 3 → `blk_cnt` stays 3.
- **Stray byte.** A `byte_vld` in IDLE → `byte_drop` = 1 and no write. `clr_flags` → `byte_drop` = 0.
- **Reset mid-block.** Assert `reset_n` low after 200 bytes → all outputs at reset values within the same cycle. The next block starts at address 0x000.

Source files
------------

// File: rtl/sdc_rd_pkg.sv
// rtl/sdc_rd_pkg.sv - shared types and constants for the SD read-path block packer
package sdc_rd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FILL     = 2'd1,
        ST_WAIT_CRC = 2'd2
    } state_t;

    localparam int SOB_BIT = 35;
    localparam int EOB_BIT = 34;
    localparam int BRAM_AW = 10;
    localparam int BRAM_DW = 36;

endpackage

// File: rtl/sdc_byte_to_word.sv
// rtl/sdc_byte_to_word.sv - packs little-endian bytes into 32-bit words, strobing on the 4th byte
module sdc_byte_to_word (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clr,
    input  logic        byte_vld,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_rdy
);

    logic [1:0]  byte_idx;
    logic [23:0] lanes;

    // The 4th byte is taken straight from the input so the word is complete in its own cycle.
    assign word_rdy = byte_vld && (byte_idx == 2'd3);
    assign word     = {byte_in, lanes};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_idx <= 2'd0;
            lanes    <= 24'd0;
        end else if (clr) begin
            byte_idx <= 2'd0;
        end else if (byte_vld) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
                2'd0:    lanes[7:0]   <= byte_in;
                2'd1:    lanes[15:8]  <= byte_in;
                2'd2:    lanes[23:16] <= byte_in;
                default: lanes        <= lanes;
            endcase
        end
    end

endmodule

// File: rtl/sdc_rd_blk_packer.sv
// rtl/sdc_rd_blk_packer.sv - writes CRC-checked 512-byte SD blocks into 8 BRAM slots
module sdc_rd_blk_packer
    import sdc_rd_pkg::*;
#(
    parameter int SLOT_BITS     = 3,
    parameter int WORDS_PER_BLK = 128
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 blk_start,
    input  logic [7:0]           byte_in,
    input  logic                 byte_vld,
    input  logic                 crc_ok,
    input  logic                 crc_err,
    input  logic                 blk_rd_done,
    input  logic                 clr_flags,
    output logic                 rdy,
    output logic [BRAM_AW-1:0]   bram_addr,
    output logic [BRAM_DW-1:0]   bram_din,
    output logic                 bram_wr,
    output logic                 blk_done,
    output logic [SLOT_BITS-1:0] blk_slot,
    output logic [3:0]           blk_cnt,
    output logic [7:0]           err_cnt,
    output logic                 byte_drop
);

    localparam int                  WIDX_W   = $clog2(WORDS_PER_BLK);
    localparam logic [WIDX_W-1:0]   LAST_IDX = WIDX_W'(WORDS_PER_BLK - 1);
    localparam logic [3:0]          SLOTS    = 4'(1 << SLOT_BITS);

    state_t                 state_q, state_d;
    logic [WIDX_W-1:0]      word_idx;
    logic [SLOT_BITS-1:0]   wr_slot;
    logic [SLOT_BITS-1:0]   rd_slot;
    logic                   start_acc, in_fill, commit, fail, drain;
    logic [31:0]            word;
    logic                   word_rdy;
    logic [BRAM_DW-1:0]     din_w;

    assign rdy       = (state_q == ST_IDLE) && (blk_cnt != SLOTS);
    assign start_acc = blk_start && rdy;
    assign in_fill   = (state_q == ST_FILL);
    // A simultaneous good/bad CRC pair is resolved as bad.
    assign fail      = (state_q == ST_WAIT_CRC) && crc_err;
    assign commit    = (state_q == ST_WAIT_CRC) && crc_ok && !crc_err;
    assign drain     = blk_rd_done && (blk_cnt != 4'd0);

    sdc_byte_to_word u_b2w (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (start_acc),
        .byte_vld (byte_vld && in_fill),
        .byte_in  (byte_in),
        .word     (word),
        .word_rdy (word_rdy)
    );

    always_comb begin
        din_w          = {{(BRAM_DW-32){1'b0}}, word};
        din_w[SOB_BIT] = (word_idx == '0);
        din_w[EOB_BIT] = (word_idx == LAST_IDX);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (start_acc) state_d = ST_FILL;
            ST_FILL:     if (word_rdy && word_idx == LAST_IDX) state_d = ST_WAIT_CRC;
            ST_WAIT_CRC: if (crc_ok || crc_err) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_idx  <= '0;
            bram_wr   <= 1'b0;
            bram_addr <= '0;
            bram_din  <= '0;
        end else begin
            bram_wr <= in_fill && word_rdy;
            if (start_acc) begin
                word_idx <= '0;
            end else if (in_fill && word_rdy) begin
                bram_addr <= {wr_slot, word_idx};
                bram_din  <= din_w;
                word_idx  <= word_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_slot  <= '0;
            rd_slot  <= '0;
            blk_done <= 1'b0;
            blk_slot <= '0;
            blk_cnt  <= 4'd0;
        end else begin
            blk_done <= commit;
            if (commit) begin
                blk_slot <= wr_slot;
                wr_slot  <= wr_slot + 1'b1;
            end
            if (drain) rd_slot <= rd_slot + 1'b1;
            if (commit && !drain)      blk_cnt <= blk_cnt + 4'd1;
            else if (drain && !commit) blk_cnt <= blk_cnt - 4'd1;
        end
    end

    // Flag clear loses to an event in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt   <= 8'd0;
            byte_drop <= 1'b0;
        end else begin
            if (fail)
                err_cnt <= clr_flags ? 8'd1 : ((err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1);
            else if (clr_flags)
                err_cnt <= 8'd0;

            if (byte_vld && !in_fill) byte_drop <= 1'b1;
            else if (clr_flags)       byte_drop <= 1'b0;
        end
    end

endmodule
